// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: raster timing generator with pixel-request port and latency-matched sync/DE/colour outputs
module vga_timing_pipe #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BEGIN  = 144,
  parameter int unsigned H_END    = 784,
  parameter int unsigned H_PERIOD = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BEGIN  = 31,
  parameter int unsigned V_END    = 511,
  parameter int unsigned V_PERIOD = 521,
  parameter int unsigned CW       = 10,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned PIX_LAT  = 1,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ce,
  output logic                 req_de,
  output logic [CW-1:0]        req_col,
  output logic [CW-1:0]        req_row,
  output logic                 line_start,
  output logic                 frame_start,
  input  logic [3*COLOR_W-1:0] pix_color,
  output logic                 vga_h_sync,
  output logic                 vga_v_sync,
  output logic                 vga_de,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B
);
  // Thresholds are one bit wider than the counters so H_END/V_END may equal 2**CW.
  localparam logic [CW:0]   HS  = (CW+1)'(H_SYNC);
  localparam logic [CW:0]   HB  = (CW+1)'(H_BEGIN);
  localparam logic [CW:0]   HE  = (CW+1)'(H_END);
  localparam logic [CW:0]   VS  = (CW+1)'(V_SYNC);
  localparam logic [CW:0]   VB  = (CW+1)'(V_BEGIN);
  localparam logic [CW:0]   VE  = (CW+1)'(V_END);
  localparam logic [CW-1:0] HL  = CW'(H_PERIOD - 1);
  localparam logic [CW-1:0] VL  = CW'(V_PERIOD - 1);
  localparam logic [CW-1:0] HB0 = CW'(H_BEGIN);
  localparam logic [CW-1:0] VB0 = CW'(V_BEGIN);
  logic [CW-1:0] hcount, vcount;
  logic [CW:0]   hx, vx;
  logic          hs_raw, vs_raw, de_raw;
  logic          hs_d, vs_d, de_d;
  assign hx          = {1'b0, hcount};
  assign vx          = {1'b0, vcount};
  assign hs_raw      = hx < HS;
  assign vs_raw      = vx < VS;
  assign de_raw      = (hx >= HB) && (hx < HE) && (vx >= VB) && (vx < VE);
  assign req_de      = de_raw;
  assign req_col     = de_raw ? hcount - HB0 : '0;
  assign req_row     = de_raw ? vcount - VB0 : '0;
  assign line_start  = hcount == '0;
  assign frame_start = (hcount == '0) && (vcount == '0);
  // Raster counters; the line counter steps only on the pixel-counter wrap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (ce) begin
      hcount <= (hcount == HL) ? '0 : hcount + 1'b1;
      if (hcount == HL) vcount <= (vcount == VL) ? '0 : vcount + 1'b1;
    end
  end
  if (PIX_LAT == 0) begin : g_direct
    assign {hs_d, vs_d, de_d} = {hs_raw, vs_raw, de_raw};
  end else begin : g_pipe
    logic [2:0] dl [PIX_LAT];
    // Delay the raw decode so it lines up with the colour returned by the pixel source.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        for (int i = 0; i < PIX_LAT; i++) dl[i] <= '0;
      end else if (ce) begin
        dl[0] <= {hs_raw, vs_raw, de_raw};
        for (int i = 1; i < PIX_LAT; i++) dl[i] <= dl[i-1];
      end
    end
    assign {hs_d, vs_d, de_d} = dl[PIX_LAT-1];
  end
  // Output register drives the pins; colour is blanked outside the active area.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vga_h_sync <= ~H_POL;
      vga_v_sync <= ~V_POL;
      vga_de     <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else if (ce) begin
      vga_h_sync <= hs_d ? H_POL : ~H_POL;
      vga_v_sync <= vs_d ? V_POL : ~V_POL;
      vga_de     <= de_d;
      {VGA_R, VGA_G, VGA_B} <= de_d ? pix_color : '0;
    end
  end
endmodule
